// File: rtl/sobel_window_pkg.sv
// -----------------------------------------------------------------------------
// sobel_window_pkg
// Shared constants and types for the 3x3 sliding-window generator.
//   SW_IMG_W / SW_IMG_H : image geometry (pixels per row / rows per frame)
//   SW_PW               : pixel width in bits
//   SW_AW               : raster address width (covers IMG_W*IMG_H)
//   SW_CW               : width of the row/column counters
//   sw_state_e          : FILL (priming line buffers) / RUN (emitting windows)
// -----------------------------------------------------------------------------
package sobel_window_pkg;

  localparam int SW_IMG_W = 64;
  localparam int SW_IMG_H = 64;
  localparam int SW_PW    = 8;
  localparam int SW_AW    = 13;
  localparam int SW_CW    = 11;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } sw_state_e;

  // Raster address of the window centre, given the raster address of the
  // pixel that completes the window (its bottom-right corner). The centre is
  // one row up and one column left, so a single subtraction suffices.
  function automatic logic [SW_AW-1:0] centre_addr(
    input logic [SW_AW-1:0] corner_addr,
    input int               img_w
  );
    return corner_addr - SW_AW'(img_w + 1);
  endfunction

endpackage

// File: rtl/sobel_window_if.sv
// -----------------------------------------------------------------------------
// sobel_window_if
// Pixel-stream input and window output of the sliding-window generator.
//   in_valid / in_pixel : one raster-ordered pixel per cycle with in_valid high
//   win_valid           : one-cycle pulse, win / win_addr hold a fresh window
//   win                 : 3x3 window, element (r,c) at [PW*(3r+c) +: PW]
//   win_addr            : raster address of the window centre
//   frame_done          : one-cycle pulse after the last pixel of a frame
//
// Handshake: there is no back-pressure. A pixel is accepted on every rising
// edge where in_valid is high; the consumer must take win whenever win_valid
// pulses. win / win_addr are stable while win_valid is low.
// Modports: master drives pixels (source side), slave is the window generator.
// -----------------------------------------------------------------------------
interface sobel_window_if #(
  parameter int PW = sobel_window_pkg::SW_PW,
  parameter int AW = sobel_window_pkg::SW_AW
) ();

  logic          in_valid;
  logic [PW-1:0] in_pixel;
  logic          win_valid;
  logic [9*PW-1:0] win;
  logic [AW-1:0] win_addr;
  logic          frame_done;

  modport master (
    output in_valid, in_pixel,
    input  win_valid, win, win_addr, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output win_valid, win, win_addr, frame_done
  );

endinterface

// File: rtl/sobel_window_line_buf.sv
// -----------------------------------------------------------------------------
// line_buf
// One image row of pixel storage, indexed by column.
//   clk     : clock
//   wr_en   : write the entry at addr this cycle (one per accepted pixel)
//   addr    : column index, shared by read and write
//   wr_data : value stored at addr
//   rd_data : current contents at addr (asynchronous read, so the value read
//             in a cycle is the one written one image row earlier)
// Contents are not reset; stale entries are never emitted by the parent.
// -----------------------------------------------------------------------------
module line_buf #(
  parameter int DEPTH = 64,
  parameter int PW    = 8,
  parameter int AIW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [AIW-1:0] addr,
  input  logic [PW-1:0]  wr_data,
  output logic [PW-1:0]  rd_data
);

  logic [PW-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window.sv
// -----------------------------------------------------------------------------
// sobel_window
// Turns a raster pixel stream into 3x3 neighbourhoods for every interior
// pixel of the image.
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   sif       : pixel input / window output (slave side of sobel_window_if)
//   dbg_state : current FILL/RUN state
//
// Two line buffers delay the stream by one and two rows; a 3x3 shift array
// collects three columns. Windows are registered into a separate output
// register so they stay stable between pulses.
// -----------------------------------------------------------------------------
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int IMG_W = SW_IMG_W,
  parameter int IMG_H = SW_IMG_H,
  parameter int PW    = SW_PW
) (
  input  logic      clk,
  input  logic      reset,
  sobel_window_if.slave sif,
  output sw_state_e dbg_state
);

  localparam int AIW = $clog2(IMG_W);

  // Counters and raster address of the next pixel to arrive
  logic [SW_CW-1:0] col_q, col_d;
  logic [SW_CW-1:0] row_q, row_d;
  logic [SW_AW-1:0] pix_addr_q, pix_addr_d;

  sw_state_e state_q, state_d;

  // 3x3 working array, [r][c]; packed so that element (r,c) lands at
  // bit offset PW*(3r+c) when viewed flat, matching the output layout.
  logic [2:0][2:0][PW-1:0] shift_q, shift_d;

  logic [9*PW-1:0]  win_q, win_d;
  logic [SW_AW-1:0] win_addr_q, win_addr_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [PW-1:0] line1_rd;
  logic [PW-1:0] line2_rd;

  logic accept;
  logic last_col;
  logic last_row;

  assign accept   = sif.in_valid;
  assign last_col = (col_q == SW_CW'(IMG_W - 1));
  assign last_row = (row_q == SW_CW'(IMG_H - 1));

  // line1 holds row-1, line2 holds row-2: each accepted pixel pushes the
  // column down one row position.
  line_buf #(
    .DEPTH (IMG_W),
    .PW    (PW),
    .AIW   (AIW)
  ) u_line1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_q[AIW-1:0]),
    .wr_data (sif.in_pixel),
    .rd_data (line1_rd)
  );

  line_buf #(
    .DEPTH (IMG_W),
    .PW    (PW),
    .AIW   (AIW)
  ) u_line2 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_q[AIW-1:0]),
    .wr_data (line1_rd),
    .rd_data (line2_rd)
  );

  // ---------------------------------------------------------------------------
  // FSM: FILL covers rows 0-1 (line buffers priming), RUN covers the rest.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept && last_col) begin
      unique case (state_q)
        FILL: if (row_q == SW_CW'(1)) state_d = RUN;
        RUN:  if (last_row)           state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pix_addr_d   = pix_addr_q;
    shift_d      = shift_q;
    win_d        = win_q;
    win_addr_d   = win_addr_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (accept) begin
      // Raster position
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + SW_CW'(1);
      end else begin
        col_d = col_q + SW_CW'(1);
      end
      pix_addr_d = (last_col && last_row) ? '0 : pix_addr_q + SW_AW'(1);

      // Shift columns left, new right column is {row-2, row-1, row}
      for (int r = 0; r < 3; r++) begin
        shift_d[r][0] = shift_q[r][1];
        shift_d[r][1] = shift_q[r][2];
      end
      shift_d[0][2] = line2_rd;
      shift_d[1][2] = line1_rd;
      shift_d[2][2] = sif.in_pixel;

      // In RUN all three rows are from this frame; col >= 2 guarantees all
      // three columns are from the current row, so no row straddling.
      if (state_q == RUN && col_q >= SW_CW'(2)) begin
        win_valid_d = 1'b1;
        win_d       = shift_d;
        win_addr_d  = centre_addr(pix_addr_q, IMG_W);
      end

      frame_done_d = last_col && last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      pix_addr_q   <= '0;
      shift_q      <= '0;
      win_q        <= '0;
      win_addr_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pix_addr_q   <= pix_addr_d;
      shift_q      <= shift_d;
      win_q        <= win_d;
      win_addr_q   <= win_addr_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sif.win_valid  = win_valid_q;
  assign sif.win        = win_q;
  assign sif.win_addr   = win_addr_q;
  assign sif.frame_done = frame_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;
  import sobel_window_pkg::*;

  localparam int W  = SW_IMG_W;
  localparam int H  = SW_IMG_H;
  localparam int PW = SW_PW;
  localparam int N  = W * H;
  localparam int WW = 9 * PW;
  localparam int QW = SW_AW + WW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic      clk = 1'b0;
  logic      reset;
  sw_state_e dbg_state;

  always #5 clk = ~clk;

  sobel_window_if #(.PW(PW), .AW(SW_AW)) sif ();

  sobel_window dut (
    .clk       (clk),
    .reset     (reset),
    .sif       (sif),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a frame image plus raster position; windows are read
  // straight out of the image array by row/column arithmetic.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    img [N];
  int               pos;
  logic             exp_valid;
  logic             exp_done;
  logic [WW-1:0]    exp_win;
  logic [SW_AW-1:0] exp_addr;
  logic [QW-1:0]    exp_q [$];

  int checks;
  int errors;

  // Observations gathered per frame
  int               pulses;
  logic [SW_AW-1:0] last_pulse_addr;
  logic             last_pulse_done;
  logic [SW_AW-1:0] first_pulse_addr;
  logic             seen_first;

  logic [WW-1:0] ramp_win130;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic model_reset();
    pos       = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_win   = '0;
    exp_addr  = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [PW-1:0] pix);
    int r;
    int c;
    logic [WW-1:0] w;
    logic [SW_AW-1:0] a;
    r = pos / W;
    c = pos % W;
    img[pos]  = pix;
    exp_valid = (r >= 2) && (c >= 2);
    exp_done  = (pos == N - 1);
    if (exp_valid) begin
      w = '0;
      for (int rr = 0; rr < 3; rr++) begin
        for (int cc = 0; cc < 3; cc++) begin
          w[PW*(3*rr+cc) +: PW] = img[(r - 2 + rr) * W + (c - 2 + cc)];
        end
      end
      a = SW_AW'((r - 1) * W + (c - 1));
      exp_q.push_back({a, w});
    end
    pos = (pos + 1) % N;
  endtask

  // Scoreboard: compare every cycle; win/addr must match the last emitted
  // window (or reset value) whether or not a pulse is present.
  task automatic compare_outputs();
    logic [QW-1:0] item;
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty observed=0 expected=1");
      end else begin
        item     = exp_q.pop_front();
        exp_addr = item[QW-1:WW];
        exp_win  = item[WW-1:0];
      end
    end
    check("win_valid",  WW'(sif.win_valid),  WW'(exp_valid));
    check("frame_done", WW'(sif.frame_done), WW'(exp_done));
    check("win",        sif.win,             exp_win);
    check("win_addr",   WW'(sif.win_addr),   WW'(exp_addr));
    if (sif.win_valid) begin
      pulses++;
      last_pulse_addr = sif.win_addr;
      last_pulse_done = sif.frame_done;
      if (!seen_first) begin
        seen_first       = 1'b1;
        first_pulse_addr = sif.win_addr;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [PW-1:0] pix);
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_pixel = pix;
    model_accept(pix);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    @(negedge clk);
    sif.in_valid = 1'b0;
    sif.in_pixel = PW'($urandom);
    exp_valid    = 1'b0;
    exp_done     = 1'b0;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_pixel = PW'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    check("reset_state", WW'(dbg_state), WW'(FILL));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_frame_stats();
    pulses           = 0;
    seen_first       = 1'b0;
    last_pulse_addr  = '0;
    last_pulse_done  = 1'b0;
    first_pulse_addr = '0;
  endtask

  task automatic check_frame_end(input string tag);
    check({tag, "_pulses"},     WW'(pulses),           WW'((H - 2) * (W - 2)));
    check({tag, "_last_addr"},  WW'(last_pulse_addr),  WW'(4030));
    check({tag, "_last_done"},  WW'(last_pulse_done),  WW'(1));
    check({tag, "_first_addr"}, WW'(first_pulse_addr), WW'(65));
    check({tag, "_end_state"},  WW'(dbg_state),        WW'(FILL));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [PW-1:0] vals [9];
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_pixel = '0;
    start_frame_stats();

    vals = '{8'd0, 8'd1, 8'd2, 8'd64, 8'd65, 8'd66, 8'd128, 8'd129, 8'd130};
    ramp_win130 = '0;
    for (int k = 0; k < 9; k++) ramp_win130[PW*k +: PW] = vals[k];

    // Step 1: reset state
    do_reset();

    // Step 2: ramp frame, 1-0-0-1 gaps over the first rows
    start_frame_stats();
    for (int i = 0; i < N; i++) begin
      send(PW'(i % 256));
      if (i == 129) check("ramp_no_win_129", WW'(sif.win_valid), WW'(0));
      if (i == 130) begin
        check("ramp_first_valid", WW'(sif.win_valid), WW'(1));
        check("ramp_first_addr",  WW'(sif.win_addr),  WW'(65));
        check("ramp_first_win",   sif.win,            ramp_win130);
      end
      if (i == 2 * W - 1) check("ramp_run_state", WW'(dbg_state), WW'(RUN));
      if (i == 192 || i == 193) check("ramp_col01_quiet", WW'(sif.win_valid), WW'(0));
      if (i == 194) begin
        check("ramp_row3_valid", WW'(sif.win_valid), WW'(1));
        check("ramp_row3_addr",  WW'(sif.win_addr),  WW'(129));
      end
      if (i < 400 && (i % 3) == 0) begin
        idle();
        idle();
      end
    end
    idle();
    check_frame_end("ramp");

    // Step 3: back-to-back random frame with random idle gaps
    start_frame_stats();
    for (int i = 0; i < N; i++) begin
      send(PW'($urandom));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    check_frame_end("rand");

    // Step 4: abandon a frame mid-way with reset
    for (int i = 0; i < 1001; i++) send(PW'($urandom));
    do_reset();

    // Step 5: fresh gap-free ramp after reset
    start_frame_stats();
    for (int i = 0; i < N; i++) begin
      send(PW'(i % 256));
      if (i == 129) check("post_reset_no_win_129", WW'(sif.win_valid), WW'(0));
      if (i == 130) begin
        check("post_reset_first_addr", WW'(sif.win_addr), WW'(65));
        check("post_reset_first_win",  sif.win,           ramp_win130);
      end
    end
    idle();
    check_frame_end("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter IMG_W, default 64: pixels per image row.
REQ-002 Parameter IMG_H, default 64: rows per image; IMG_W*IMG_H = 4096 pixels per frame.
REQ-003 Parameter PW, default 8: pixel width in bits.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 in_valid  input  1: in_pixel is presented this cycle; raster order, one pixel per asserted cycle, arbitrary idle gaps allowed.
REQ-007 in_pixel  input  PW: pixel data.
REQ-008 win_valid  output  1: win and win_addr hold a complete 3x3 neighbourhood this cycle; one-cycle pulse.
REQ-009 win  output  9*PW: window; element (r,c) at bits [PW*(3r+c) +: PW]; r=0 is the top (oldest) row, c=0 the left (oldest) column, (1,1) the centre.
REQ-010 win_addr  output  13: raster address of the centre pixel, row*IMG_W+col.
REQ-011 frame_done  output  1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL keep 11-bit... column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both advancing only on in_valid.
REQ-013 col SHALL wrap from IMG_W-1 to 0 and increment row; row SHALL wrap from IMG_H-1 to 0 at frame end.
REQ-014 SHALL hold two line buffers of IMG_W entries each, holding rows row-1 and row-2 at the current column; each accepted pixel shifts down one row position.
REQ-015 SHALL hold a 3x3 register array; on each accepted pixel, columns shift left and the new right column is {line2[col], line1[col], in_pixel}.
REQ-016 win_valid SHALL assert the cycle after an accepted pixel at row>=2 and col>=2, i.e., only interior centres (1..IMG_H-2, 1..IMG_W-2) are emitted.
REQ-017 Latency: accepted pixel at (row,col) -> win_valid, win, win_addr = (row-1)*IMG_W+(col-1) on the next rising edge.
REQ-018 No window SHALL be emitted for col 0 or 1; windows SHALL never straddle a row boundary.
REQ-019 win and win_addr SHALL hold their last value while win_valid is low.
REQ-020 Cycles with in_valid low SHALL change no state apart from clearing win_valid and frame_done.
REQ-021 Exactly (IMG_H-2)*(IMG_W-2) = 3844 windows SHALL be emitted per frame.
REQ-022 State machine: FILL (rows 0-1, no output), RUN (rows 2..IMG_H-1), FILL again after the last pixel.
REQ-023 FILL->RUN on the accepted pixel at row 1, col IMG_W-1; RUN->FILL on the accepted pixel at row IMG_H-1, col IMG_W-1.
REQ-024 The RUN->FILL pixel SHALL produce win_valid and frame_done in the same cycle.
REQ-025 Line-buffer contents from a previous frame SHALL never reach win, since FILL suppresses output.

Reset
REQ-026 On reset: row=0, col=0, state=FILL.
REQ-027 On reset: win_valid=0, frame_done=0, win=0, win_addr=0.
REQ-028 Line-buffer contents need not be cleared.
REQ-029 Reset mid-frame SHALL abandon the frame; the next accepted pixel is pixel (0,0).

Structure
REQ-030 The shared package SHALL hold IMG_W, IMG_H, PW, address width 13, and the state enumeration {FILL, RUN}.
REQ-031 A sub-module line_buf (IMG_W x PW, one read and one write per accepted pixel at col) SHALL be instantiated twice.
REQ-032 win_addr SHALL be computed from registered counters, with no multiplier (row concatenated with col for power-of-two IMG_W).

Verification
REQ-033 Ramp frame, pixel value = index mod 256 -> first win_valid after pixel 130; win_addr=65; win = {0,1,2,64,65,66,128,129,130}.
REQ-034 Ramp frame -> no win_valid after pixels 192 and 193; after pixel 194, win_addr=129.
REQ-035 Full frame -> 3844 win_valid pulses; last pulse has win_addr=4030, coincident with frame_done.
REQ-036 in_valid toggled 1-0-0-1 -> outputs identical to the gap-free run, delayed only by the idle cycles.
REQ-037 Reset after pixel 1000, then a new ramp frame -> first win_valid again after pixel 130 with win_addr=65, and no stale data.
REQ-038 Two back-to-back frames -> the second frame's first window has win_addr=65 and contains no first-frame pixels.
